// File: rtl/cr_mem_check_master.sv
// Memory self-test initiator: writes an address-derived pattern over a wrapping range, reads it back and checks it.
// Optional CR_MEM_CHECK_ERR_CAPTURE_EN: latch address/data of the first mismatch after each start.
module cr_mem_check_master #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 4,
  parameter int MAX_OUTST  = 8,
  parameter int TIMEOUT    = 8
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_first,
  input  logic [ADDR_W-1:0] addr_last,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic              proto_err,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              mem_wr_write,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rd_read,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  if (MAX_OUTST < RD_LATENCY || (1 << PW) != MAX_OUTST) begin : g_bad_cfg
    $error("MAX_OUTST must be a power of 2 and >= RD_LATENCY");
  end

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q, span_q, idx_q, cur_addr;
  logic [DATA_W-1:0] seed_q;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [TW-1:0]     tmo_q;
  logic              result_vld;
  logic [DATA_W-1:0] fifo_data [MAX_OUTST];

  logic accept, last_idx, fifo_empty, fifo_full, issue, resp_act, pop, spurious, mismatch, timeout_hit;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] s);
    return {~a, a} ^ s;
  endfunction

  assign cur_addr    = base_q + idx_q;
  assign last_idx    = (idx_q == span_q);
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == (PW+1)'(MAX_OUTST));
  assign accept      = (state == S_IDLE) && start;
  assign issue       = (state == S_READ) && !fifo_full;
  // Returns outside READ/DRAIN are stale (e.g. in flight across a reset) and are dropped.
  assign resp_act    = mem_rd_valid && (state == S_READ || state == S_DRAIN);
  assign pop         = resp_act && !fifo_empty;
  assign spurious    = resp_act && fifo_empty;
  assign mismatch    = pop && (mem_rd_data != fifo_data[rd_ptr]);
  assign timeout_hit = (state == S_DRAIN) && !mem_rd_valid && !fifo_empty && (tmo_q == TW'(TIMEOUT - 1));

  assign mem_wr_write = (state == S_WRITE);
  assign mem_wr_addr  = cur_addr;
  assign mem_wr_data  = pat(cur_addr, seed_q);
  assign mem_rd_read  = issue;
  assign mem_rd_addr  = cur_addr;
  assign busy         = (state == S_WRITE) || (state == S_GAP) || (state == S_READ) || (state == S_DRAIN);
  assign done         = (state == S_DONE);
  assign pass         = (done || result_vld) && (err_cnt == 16'd0) && !proto_err;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_WRITE;
      S_WRITE: if (last_idx) state_nxt = S_GAP;
      S_GAP:   state_nxt = S_READ;
      S_READ:  if (issue && last_idx) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_empty || timeout_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state      <= S_IDLE;
      base_q     <= '0;
      span_q     <= '0;
      seed_q     <= '0;
      idx_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tmo_q      <= '0;
      err_cnt    <= '0;
      proto_err  <= 1'b0;
      result_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base_q     <= addr_first;
        span_q     <= addr_last - addr_first;
        seed_q     <= seed;
        idx_q      <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        tmo_q      <= '0;
        err_cnt    <= '0;
        proto_err  <= 1'b0;
        result_vld <= 1'b0;
      end else begin
        if (state == S_WRITE) idx_q <= last_idx ? '0 : idx_q + 1'b1;
        if (issue) begin
          idx_q  <= idx_q + 1'b1;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({issue, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (state == S_DRAIN && !mem_rd_valid && !fifo_empty) tmo_q <= tmo_q + 1'b1;
        else tmo_q <= '0;
        if (mismatch && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (spurious || timeout_hit) proto_err <= 1'b1;
        if (state == S_DONE) result_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) fifo_data[wr_ptr] <= pat(cur_addr, seed_q);
  end

`ifdef CR_MEM_CHECK_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] fifo_addr [MAX_OUTST];

  always_ff @(posedge clk) begin
    if (issue) fifo_addr[wr_ptr] <= cur_addr;
  end

  // err_cnt still zero marks the first mismatch since start.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (accept) begin
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (mismatch && err_cnt == 16'd0) begin
      first_err_addr <= fifo_addr[rd_ptr];
      first_err_data <= mem_rd_data;
    end
  end
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

endmodule

// File: tb/tb_cr_mem_check_master.sv
// Bench for cr_mem_check_master: 256x16 RAM responder with fixed read latency, write and result scoreboards.
module tb_cr_mem_check_master;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset_p, start;
  logic [7:0]  addr_first, addr_last;
  logic [15:0] seed;
  logic        busy, done, pass, proto_err;
  logic [15:0] err_cnt;
  logic [7:0]  first_err_addr;
  logic [15:0] first_err_data;
  logic        mem_wr_write, mem_rd_read, mem_rd_valid;
  logic [7:0]  mem_wr_addr, mem_rd_addr;
  logic [15:0] mem_wr_data, mem_rd_data;

  cr_mem_check_master #(.ADDR_W(8), .DATA_W(16), .RD_LATENCY(LAT), .MAX_OUTST(8), .TIMEOUT(8)) dut (
    .clk(clk), .reset_p(reset_p), .start(start), .addr_first(addr_first), .addr_last(addr_last),
    .seed(seed), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .proto_err(proto_err),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .mem_wr_write(mem_wr_write), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_read(mem_rd_read), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid)
  );

  always #5 clk = ~clk;

  // RAM responder: read data returned LAT clocks after the read is sampled.
  logic [15:0]    ram [256];
  logic [LAT-1:0] pv = '0;
  logic [7:0]     pa [LAT];
  logic [15:0]    pd [LAT];
  bit flip_en = 0, drop_en = 0, spur = 0;

  always @(posedge clk) begin
    if (mem_wr_write) ram[mem_wr_addr] <= mem_wr_data;
    pv    <= {pv[LAT-2:0], mem_rd_read};
    pa[0] <= mem_rd_addr;
    pd[0] <= ram[mem_rd_addr];
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pd[i] <= pd[i-1];
    end
  end

  assign mem_rd_valid = (pv[LAT-1] & ~drop_en) | spur;
  assign mem_rd_data  = pd[LAT-1] ^ {15'd0, (flip_en && pa[LAT-1] == 8'h10)};

  typedef struct packed {logic [7:0] a; logic [15:0] d;} wr_t;
  typedef struct packed {logic p; logic [15:0] e; logic pe; logic [7:0] fa; logic [15:0] fd;} res_t;
  wr_t  wr_q[$];
  res_t res_q[$];
  int n_vec = 0, n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [15:0] s);
    return {~a, a} ^ s;
  endfunction

  always @(negedge clk) begin
    wr_t w;
    res_t r;
    if (mem_wr_write) begin
      if (wr_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected none", mem_wr_addr, mem_wr_data);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", mem_wr_addr, w.a);
        check("wr_data", mem_wr_data, w.d);
      end
    end
    if (done) begin
      if (res_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_done: got done, expected none");
      end else begin
        r = res_q.pop_front();
        check("pass", pass, r.p);
        check("err_cnt", err_cnt, r.e);
        check("proto_err", proto_err, r.pe);
        check("busy_at_done", busy, 0);
        check("first_err_addr", first_err_addr, r.fa);
        check("first_err_data", first_err_data, r.fd);
      end
    end
  end

  task automatic push_model(input logic [7:0] f, input logic [7:0] l, input logic [15:0] s);
    logic [7:0] n, a;
    n = l - f;
    for (int i = 0; i <= int'(n); i++) begin
      a = f + 8'(i);
      wr_q.push_back('{a, model(a, s)});
    end
  endtask

  task automatic kick(input logic [7:0] f, input logic [7:0] l, input logic [15:0] s);
    @(negedge clk);
    addr_first = f; addr_last = l; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; addr_first = ~f; addr_last = ~l; seed = ~s;
  endtask

  task automatic run(input logic [7:0] f, input logic [7:0] l, input logic [15:0] s,
                     input bit ep, input logic [15:0] ee, input bit epe,
                     input logic [7:0] fa, input logic [15:0] fd, input bit poke, output int lat);
    int cyc;
    res_q.push_back('{ep, ee, epe, fa, fd});
    kick(f, l, s);
    cyc = 1;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 10);
      if (start) begin addr_first = 8'h40; addr_last = 8'h41; end
    end
    start = 1'b0;
    lat = cyc - 1;
    if (!done) begin
      n_vec++; n_miss++;
      $display("FAIL run_timeout: got no done after %0d clks, expected done", cyc);
    end
    @(negedge clk);
  endtask

  initial begin
    int lat, k;
    logic [7:0] fa4;
    logic [15:0] fd4;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    reset_p = 1'b1; start = 1'b0; addr_first = '0; addr_last = '0; seed = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_wr_rd", {mem_wr_write, mem_rd_read}, 0);
    @(negedge clk);
    reset_p = 1'b0;

    // Full range, plus an ignored start while busy.
    push_model(8'h00, 8'hFF, 16'h0000);
    run(8'h00, 8'hFF, 16'h0000, 1, 0, 0, 0, 0, 1, lat);

    // Wrapping range FE..01.
    wr_q.push_back('{8'hFE, 16'h5BA4});
    wr_q.push_back('{8'hFF, 16'h5AA5});
    wr_q.push_back('{8'h00, 16'hA55A});
    wr_q.push_back('{8'h01, 16'hA45B});
    run(8'hFE, 8'h01, 16'h5A5A, 1, 0, 0, 0, 0, 0, lat);
    check("ram_02_untouched", ram[8'h02], 16'hFD02);
    check("ram_FD_untouched", ram[8'hFD], 16'h02FD);
    check("ram_FE", ram[8'hFE], 16'h5BA4);

    // Single address; start-to-done latency.
    wr_q.push_back('{8'h80, 16'h7F80});
    run(8'h80, 8'h80, 16'h0000, 1, 0, 0, 0, 0, 0, lat);
    check("single_latency", lat, 8);

    // Corrupted read data at 0x10.
`ifdef CR_MEM_CHECK_ERR_CAPTURE_EN
    fa4 = 8'h10; fd4 = 16'hFD25;
`else
    fa4 = 8'h00; fd4 = 16'h0000;
`endif
    flip_en = 1;
    push_model(8'h0C, 8'h13, 16'h1234);
    run(8'h0C, 8'h13, 16'h1234, 0, 1, 0, fa4, fd4, 0, lat);
    flip_en = 0;
    repeat (3) @(negedge clk);
    check("err_cnt_hold", err_cnt, 1);
    check("pass_hold", pass, 0);

    // Responses suppressed: DRAIN timeout.
    drop_en = 1;
    push_model(8'h40, 8'h41, 16'h0000);
    run(8'h40, 8'h41, 16'h0000, 0, 0, 1, 0, 0, 0, lat);
    drop_en = 0;
    repeat (6) @(negedge clk);

    // Spurious valid on the first READ cycle (FIFO still empty).
    push_model(8'h50, 8'h52, 16'hFFFF);
    fork
      run(8'h50, 8'h52, 16'hFFFF, 0, 0, 1, 0, 0, 0, lat);
      begin
        k = 0;
        while (!mem_rd_read && k < 200) begin @(negedge clk); k++; end
        spur = 1;
        @(negedge clk);
        spur = 0;
      end
    join

    // Reset in the middle of READ.
    push_model(8'h20, 8'h2F, 16'h0000);
    kick(8'h20, 8'h2F, 16'h0000);
    k = 0;
    while (!mem_rd_read && k < 200) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    reset_p = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pass", pass, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_proto_err", proto_err, 0);
    check("midrst_rd", mem_rd_read, 0);
    @(negedge clk);
    reset_p = 1'b0;

    push_model(8'h20, 8'h2F, 16'h0F0F);
    run(8'h20, 8'h2F, 16'h0F0F, 1, 0, 0, 0, 0, 0, lat);

    check("wr_q_drained", wr_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
